up_datapath: RTL and testbench
==============================

UP_DATAPATH -- requirements
Module: up_datapath

Interface
REQ-001 SHALL have port CLOCK  in  1  system clock; all registers update on the rising edge.
REQ-002 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt  in  1 each  control strobes from the control unit.
REQ-004 SHALL have port Asel  in  2  accumulator source select: 00 = ALU result, 01 = Input, 10 = memory read data, 11 = 8'h00.
REQ-005 SHALL have port Input  in  8  user data switches.
REQ-006 SHALL have ports ProgWe  in  1, ProgAddr  in  5, ProgData  in  8  program-preload write port.
REQ-007 SHALL have port IR  out  3  opcode field, IR register bits [7:5].
REQ-008 SHALL have ports Aeq0  out  1 and Apos  out  1  accumulator status flags.
REQ-009 SHALL have ports Output  out  8 (accumulator value), PCout  out  5 (program counter), Halted  out  1 (sticky halt flag).

Function
REQ-010 SHALL contain a 32x8 memory with synchronous read: rdata <= M[maddr] on every rising edge.
REQ-011 SHALL drive maddr = IR[4:0] when Meminst=1, else PC.
REQ-012 SHALL perform a synchronous write M[maddr] <= A when MemWr=1 and ProgWe=0.
REQ-013 SHALL write M[ProgAddr] <= ProgData when ProgWe=1; ProgWe has priority over MemWr, and the MemWr write is dropped in the same cycle.
REQ-014 SHALL return the old contents on a read-during-write to the same address.
REQ-015 SHALL load IR <= rdata (full 8 bits) when IRload=1, and otherwise hold IR.
REQ-016 SHALL update PC when PCload=1: PC <= IR[4:0] if JMPmux=1, else PC+1 modulo 32 (31 -> 0). PC SHALL hold when PCload=0.
REQ-017 SHALL form ALU result = A + rdata when Sub=0 and A - rdata when Sub=1, 8-bit modulo, with no carry/overflow output.
REQ-018 SHALL load A <= the Asel-selected source when Aload=1, and otherwise hold A.
REQ-019 SHALL drive Aeq0 = (A == 0) and Apos = ~A[7] (non-negative) combinationally from the A register.
REQ-020 SHALL set Halted <= 1 on any rising edge with Halt=1; Halted SHALL stay set until RESET.
REQ-021 SHALL not gate register updates with Halted; freezing the machine is the control unit's job.
REQ-022 SHALL produce the following cycle-level behaviour with the standard control sequence:
- START edge: latches M[PC] into rdata.
- FETCH edge: IR <= M[PC] and PC <= PC+1.
- DECODE edge: latches M[IR[4:0]] into rdata.
- Execute state: consumes that rdata.
REQ-023 SHALL accept any control combination without hazard; simultaneous IRload, PCload and Aload all take effect on the same edge.

Reset
REQ-024 SHALL on RESET clear IR, PC, A, rdata and Halted to 0 immediately, independent of CLOCK; resulting outputs are Output=0, PCout=0, IR=000, Aeq0=1, Apos=1, Halted=0.
REQ-025 SHALL not clear memory contents on RESET; ProgWe writes SHALL be honoured while RESET=1 so a program can be preloaded with the core held in reset.
REQ-026 SHALL complete no write on the edge at which RESET is asserted mid-operation, except for a ProgWe write.

Structure
REQ-027 SHALL place DATA_W=8, ADDR_W=5, MEM_DEPTH=32, the Asel encodings (ASEL_ALU, ASEL_IN, ASEL_MEM, ASEL_ZERO) and the 3-bit opcode constants (LOAD..HALT = 000..111) in shared package up_pkg, used by the control unit and the datapath.
REQ-028 SHALL instantiate the memory as sub-module up_ram32x8 (one synchronous read port, one synchronous write port, read-old-data).

Verification
REQ-029 Preload test: ProgWe under RESET, M[0]=8'h1E (LOAD 30), M[30]=8'h05, then START/FETCH/DECODE/LOAD -> IR=000, PC=1, Output=8'h05, Aeq0=0, Apos=1.
REQ-030 Add/sub wrap test: A=8'hFF, M[3]=8'h01, ADD with IR[4:0]=3 -> A=8'h00, Aeq0=1; then SUB with M[3]=8'h01 -> A=8'hFF, Apos=0.
REQ-031 Jump test: JZ with IR=8'hB4 and A=0 -> PC=20; with A=8'h07 -> PC unchanged; JPOS with A=8'h80 -> PC unchanged.
REQ-032 STORE/collision test: A=8'h5A, STORE to address 9 -> M[9]=8'h5A; same cycle with ProgWe, ProgAddr=9, ProgData=8'h33 -> M[9]=8'h33; read-during-write returns old value.
REQ-033 PC wrap and INPUT test: PC=31 with FETCH -> PC=0; Asel=01, Input=8'hC3, Aload -> Output=8'hC3, Apos=0.
REQ-034 Halt/reset test: Halt pulse -> Halted=1 and persists; async RESET mid-cycle -> all registers 0 before the next CLOCK edge, memory retained.

Source files
------------

// File: rtl/up_pkg.sv
`default_nettype none
// ============================================================================
// Module      : up_pkg
// Description : Shared widths, accumulator source encodings and opcodes for
//               the microprocessor control unit and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package up_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 5;
    localparam int MEM_DEPTH = 32;

    typedef enum logic [1:0] {
        ASEL_ALU  = 2'b00,
        ASEL_IN   = 2'b01,
        ASEL_MEM  = 2'b10,
        ASEL_ZERO = 2'b11
    } asel_t;

    typedef enum logic [2:0] {
        LOAD  = 3'b000,
        STORE = 3'b001,
        ADD   = 3'b010,
        SUB   = 3'b011,
        INPUT = 3'b100,
        JZ    = 3'b101,
        JPOS  = 3'b110,
        HALT  = 3'b111
    } opcode_t;

endpackage : up_pkg
`default_nettype wire

// File: rtl/up_ram32x8.sv
`default_nettype none
// ============================================================================
// Module      : up_ram32x8
// Description : 32x8 memory, one synchronous write port and one registered
//               read port returning old data on a same-address collision.
// Revision    : 1.0 - initial release
// ============================================================================
module up_ram32x8
    import up_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array is deliberately outside the reset domain so a preloaded program survives RESET.
    always_ff @(posedge CLOCK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : up_ram32x8
`default_nettype wire

// File: rtl/up_datapath.sv
`default_nettype none
// ============================================================================
// Module      : up_datapath
// Description : Accumulator-machine datapath: IR, PC, accumulator, ALU,
//               sticky halt flag and program memory with a preload port.
// Revision    : 1.0 - initial release
// ============================================================================
module up_datapath
    import up_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              IRload,
    input  logic              PCload,
    input  logic              JMPmux,
    input  logic              Meminst,
    input  logic              MemWr,
    input  logic              Aload,
    input  logic              Sub,
    input  logic              Halt,
    input  logic [1:0]        Asel,
    input  logic [DATA_W-1:0] Input,
    input  logic              ProgWe,
    input  logic [ADDR_W-1:0] ProgAddr,
    input  logic [DATA_W-1:0] ProgData,
    output logic [2:0]        IR,
    output logic              Aeq0,
    output logic              Apos,
    output logic [DATA_W-1:0] Output,
    output logic [ADDR_W-1:0] PCout,
    output logic              Halted
);

    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic              r_halted;

    logic [ADDR_W-1:0] w_maddr;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_asel_data;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_maddr = Meminst ? r_ir[ADDR_W-1:0] : r_pc;
    assign w_alu   = Sub ? (r_a - w_rdata) : (r_a + w_rdata);

    // Preload port wins; a datapath store is suppressed while RESET is high.
    assign w_we    = ProgWe | (MemWr & ~RESET);
    assign w_waddr = ProgWe ? ProgAddr : w_maddr;
    assign w_wdata = ProgWe ? ProgData : r_a;

    always_comb begin
        w_asel_data = '0;
        case (Asel)
            ASEL_ALU:  w_asel_data = w_alu;
            ASEL_IN:   w_asel_data = Input;
            ASEL_MEM:  w_asel_data = w_rdata;
            ASEL_ZERO: w_asel_data = '0;
            default:   w_asel_data = '0;
        endcase
    end

    up_ram32x8 u_ram (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_maddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_ir     <= '0;
            r_pc     <= '0;
            r_a      <= '0;
            r_halted <= 1'b0;
        end else begin
            if (IRload) begin
                r_ir <= w_rdata;
            end
            if (PCload) begin
                r_pc <= JMPmux ? r_ir[ADDR_W-1:0] : r_pc + 5'd1;
            end
            if (Aload) begin
                r_a <= w_asel_data;
            end
            if (Halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign IR     = r_ir[7:5];
    assign Aeq0   = (r_a == '0);
    assign Apos   = ~r_a[DATA_W-1];
    assign Output = r_a;
    assign PCout  = r_pc;
    assign Halted = r_halted;

endmodule : up_datapath
`default_nettype wire

// File: tb/tb_up_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_up_datapath
// Description : Directed instruction scenarios plus randomized control traffic
//               against a behavioural model of the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_datapath;
    import up_pkg::*;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [7:0] Input;
    logic       ProgWe;
    logic [4:0] ProgAddr;
    logic [7:0] ProgData;
    logic [2:0] IR;
    logic       Aeq0, Apos;
    logic [7:0] Output;
    logic [4:0] PCout;
    logic       Halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [32];
    logic [7:0] m_ir, m_a, m_rd;
    logic [4:0] m_pc;
    logic       m_halted;

    always #5 CLOCK = ~CLOCK;

    up_datapath dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst),
        .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Halt(Halt),
        .Asel(Asel), .Input(Input),
        .ProgWe(ProgWe), .ProgAddr(ProgAddr), .ProgData(ProgData),
        .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Output(Output), .PCout(PCout),
        .Halted(Halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_ctl();
        IRload = 0; PCload = 0; JMPmux = 0; Meminst = 0; MemWr = 0;
        Aload = 0; Sub = 0; Halt = 0; Asel = 2'b00; Input = 8'h00;
        ProgWe = 0; ProgAddr = 5'd0; ProgData = 8'h00;
    endtask

    task automatic model_clear();
        m_ir = 8'h00; m_a = 8'h00; m_rd = 8'h00; m_pc = 5'd0; m_halted = 1'b0;
    endtask

    // What one rising edge does to the machine, given the controls present at it.
    task automatic model_edge();
        logic [4:0] addr;
        logic [7:0] fetched;
        if (RESET) begin
            if (ProgWe) m_mem[ProgAddr] = ProgData;
            return;
        end
        addr    = Meminst ? m_ir[4:0] : m_pc;
        fetched = m_mem[addr];
        if (ProgWe)     m_mem[ProgAddr] = ProgData;
        else if (MemWr) m_mem[addr] = m_a;
        if (Aload) begin
            if (Asel == 2'd0)      m_a = Sub ? 8'(m_a - m_rd) : 8'(m_a + m_rd);
            else if (Asel == 2'd1) m_a = Input;
            else if (Asel == 2'd2) m_a = m_rd;
            else                   m_a = 8'h00;
        end
        if (PCload) m_pc = JMPmux ? m_ir[4:0] : 5'((m_pc + 1) % 32);
        if (IRload) m_ir = m_rd;
        m_rd = fetched;
        if (Halt) m_halted = 1'b1;
    endtask

    task automatic compare_all();
        check_eq("output", Output, m_a);
        check_eq("pc", PCout, m_pc);
        check_eq("ir", IR, m_ir[7:5]);
        check_eq("aeq0", Aeq0, m_a == 8'h00);
        check_eq("apos", Apos, m_a < 8'h80);
        check_eq("halted", Halted, m_halted);
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_edge();
        #1;
        compare_all();
        clear_ctl();
    endtask

    task automatic prog(input logic [4:0] addr, input logic [7:0] data);
        ProgWe = 1; ProgAddr = addr; ProgData = data;
        tick();
    endtask

    task automatic set_a(input logic [7:0] v);
        Aload = 1; Asel = 2'b01; Input = v;
        tick();
    endtask

    // START, FETCH, DECODE: leaves M[IR[4:0]] latched for the execute edge.
    task automatic fetch_decode();
        tick();
        IRload = 1; PCload = 1;
        tick();
        Meminst = 1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ctl();
        RESET = 1'b1;
        model_clear();
        #2;
        compare_all();

        // Preload every location under reset so the model knows all of memory.
        for (int i = 0; i < 32; i++) prog(5'(i), 8'($urandom));
        prog(5'd0, 8'h1E);
        prog(5'd30, 8'h05);
        #2;
        RESET = 1'b0;

        // LOAD 30 from address 0
        fetch_decode();
        Aload = 1; Asel = 2'b10;
        tick();
        check_eq("pre_ir", IR, 3'b000);
        check_eq("pre_pc", PCout, 5'd1);
        check_eq("pre_out", Output, 8'h05);
        check_eq("pre_aeq0", Aeq0, 1'b0);
        check_eq("pre_apos", Apos, 1'b1);

        // ADD wraps to zero, SUB wraps back to FF
        prog(5'd1, 8'h43);
        prog(5'd2, 8'h63);
        prog(5'd3, 8'h01);
        set_a(8'hFF);
        fetch_decode();
        Aload = 1; Asel = 2'b00; Sub = 0;
        tick();
        check_eq("add_wrap", Output, 8'h00);
        check_eq("add_aeq0", Aeq0, 1'b1);
        fetch_decode();
        Aload = 1; Asel = 2'b00; Sub = 1;
        tick();
        check_eq("sub_wrap", Output, 8'hFF);
        check_eq("sub_apos", Apos, 1'b0);

        // JZ 20 taken with A=0, not taken with A=07; JPOS not taken with A=80
        prog(5'd3, 8'hB4);
        Aload = 1; Asel = 2'b11;
        tick();
        fetch_decode();
        PCload = Aeq0; JMPmux = Aeq0;
        tick();
        check_eq("jz_taken", PCout, 5'd20);
        set_a(8'h07);
        PCload = Aeq0; JMPmux = Aeq0;
        tick();
        check_eq("jz_not", PCout, 5'd20);
        set_a(8'h80);
        PCload = Apos; JMPmux = Apos;
        tick();
        check_eq("jpos_not", PCout, 5'd20);

        // STORE 9 colliding with a preload write, then a plain STORE
        prog(5'd20, 8'h29);
        prog(5'd9, 8'h11);
        set_a(8'h5A);
        fetch_decode();
        Meminst = 1; MemWr = 1; ProgWe = 1; ProgAddr = 5'd9; ProgData = 8'h33;
        tick();
        Aload = 1; Asel = 2'b10;
        tick();
        check_eq("rdw_old", Output, 8'h11);
        Meminst = 1;
        tick();
        Aload = 1; Asel = 2'b10;
        tick();
        check_eq("prog_wins", Output, 8'h33);
        set_a(8'h5A);
        Meminst = 1; MemWr = 1;
        tick();
        Meminst = 1;
        tick();
        Aload = 1; Asel = 2'b10;
        tick();
        check_eq("store", Output, 8'h5A);

        // PC wrap 31 -> 0, then INPUT
        prog(5'd21, 8'h1F);
        tick();
        IRload = 1; PCload = 1;
        tick();
        PCload = 1; JMPmux = 1;
        tick();
        check_eq("pc_31", PCout, 5'd31);
        PCload = 1;
        tick();
        check_eq("pc_wrap", PCout, 5'd0);
        set_a(8'hC3);
        check_eq("input_out", Output, 8'hC3);
        check_eq("input_apos", Apos, 1'b0);

        // Sticky halt, then asynchronous reset between edges
        Halt = 1;
        tick();
        check_eq("halt_set", Halted, 1'b1);
        tick();
        tick();
        check_eq("halt_sticky", Halted, 1'b1);
        #2;
        RESET = 1'b1;
        model_clear();
        #1;
        compare_all();
        check_eq("rst_out", Output, 8'h00);
        check_eq("rst_halted", Halted, 1'b0);
        check_eq("rst_aeq0", Aeq0, 1'b1);
        RESET = 1'b0;
        tick();
        Aload = 1; Asel = 2'b10;
        tick();
        check_eq("mem_retained", Output, 8'h1E);

        // Randomized control traffic, with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                RESET = 1'b1;
                model_clear();
            end else begin
                RESET = 1'b0;
            end
            IRload   = 1'($urandom_range(0, 1));
            PCload   = 1'($urandom_range(0, 1));
            JMPmux   = 1'($urandom_range(0, 1));
            Meminst  = 1'($urandom_range(0, 1));
            MemWr    = ($urandom_range(0, 2) == 0);
            Aload    = 1'($urandom_range(0, 1));
            Sub      = 1'($urandom_range(0, 1));
            Halt     = ($urandom_range(0, 29) == 0);
            Asel     = 2'($urandom_range(0, 3));
            Input    = 8'($urandom);
            ProgWe   = ($urandom_range(0, 3) == 0);
            ProgAddr = 5'($urandom);
            ProgData = 8'($urandom);
            tick();
        end
        RESET = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_up_datapath
`default_nettype wire
